// File: rtl/audio_pkg.sv
// Shared widths and voice indices for the three-voice audio mixer.
package audio_pkg;

  localparam int unsigned ENV_W = 5;
  localparam logic [ENV_W-1:0] ENV_MAX = 5'd31;
  localparam int unsigned MIX_W = 7;
  localparam int unsigned ACC_W = 7;

  localparam int unsigned V_KICK  = 0;
  localparam int unsigned V_SNARE = 1;
  localparam int unsigned V_LEAD  = 2;

endpackage

// File: rtl/audio_envelope.sv
// Single-voice 5-bit envelope: trig reloads to max, frame tick decays
// by DECAY and saturates at zero.
module audio_envelope
  import audio_pkg::*;
#(
  parameter int unsigned DECAY = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             frame_tick,
  input  logic             trig,
  output logic [ENV_W-1:0] env
);

  localparam logic [ENV_W-1:0] DEC = ENV_W'(DECAY);

  logic [ENV_W-1:0] env_q;
  logic [ENV_W-1:0] env_d;

  // trig has priority over the frame decay
  always_comb begin
    env_d = env_q;
    if (trig) begin
      env_d = ENV_MAX;
    end else if (frame_tick) begin
      env_d = (env_q > DEC) ? env_q - DEC : '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      env_q <= '0;
    end else begin
      env_q <= env_d;
    end
  end

  assign env = env_q;

endmodule

// File: rtl/audio_voice_mixer.sv
// Per-voice envelopes, gated 7-bit mix and first-order sigma-delta
// modulator driving the 1-bit audio pin.
module audio_voice_mixer
  import audio_pkg::*;
#(
  parameter int unsigned NUM_VOICES = 3,
  parameter int unsigned DECAY0     = 1,
  parameter int unsigned DECAY1     = 2,
  parameter int unsigned DECAY2     = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  frame_tick,
  input  logic [NUM_VOICES-1:0] trig,
  input  logic [NUM_VOICES-1:0] gate,
  output logic [MIX_W-1:0]      mix,
  output logic                  pdm_out
);

  logic [ENV_W-1:0] env [NUM_VOICES];

  for (genvar i = 0; i < NUM_VOICES; i++) begin : g_voice
    localparam int unsigned DEC =
      (i == V_KICK)  ? DECAY0 :
      (i == V_SNARE) ? DECAY1 : DECAY2;

    audio_envelope #(
      .DECAY(DEC)
    ) u_env (
      .clk       (clk),
      .rst_n     (rst_n),
      .frame_tick(frame_tick),
      .trig      (trig[i]),
      .env       (env[i])
    );
  end

  logic [MIX_W-1:0] mix_q;
  logic [MIX_W-1:0] mix_d;
  logic [ACC_W-1:0] acc_q;
  logic [ACC_W-1:0] acc_d;
  logic             pdm_q;
  logic             pdm_d;

  // 3 x 31 = 93 fits in 7 bits, so no clipping
  always_comb begin
    mix_d = '0;
    for (int i = 0; i < NUM_VOICES; i++) begin
      if (gate[i]) begin
        mix_d = mix_d + MIX_W'(env[i]);
      end
    end
  end

  // carry out of acc + mix is the density bit
  always_comb begin
    {pdm_d, acc_d} = {1'b0, acc_q} + {1'b0, mix_q};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mix_q <= '0;
      acc_q <= '0;
      pdm_q <= 1'b0;
    end else begin
      mix_q <= mix_d;
      acc_q <= acc_d;
      pdm_q <= pdm_d;
    end
  end

  assign mix     = mix_q;
  assign pdm_out = pdm_q;

endmodule

// File: tb/tb_audio_voice_mixer.sv
// Self-checking bench for audio_voice_mixer against an arithmetic
// reference model of envelopes, mix and sigma-delta.
module tb_audio_voice_mixer;

  logic       clk;
  logic       rst_n;
  logic       frame_tick;
  logic [2:0] trig;
  logic [2:0] gate;
  logic [6:0] mix;
  logic       pdm_out;

  int checks = 0;
  int errors = 0;

  int m_env [3];
  int m_mix;
  int m_acc;
  int m_pdm;
  int dec [3] = '{1, 2, 2};

  audio_voice_mixer dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .frame_tick(frame_tick),
    .trig      (trig),
    .gate      (gate),
    .mix       (mix),
    .pdm_out   (pdm_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic model_reset();
    for (int i = 0; i < 3; i++) m_env[i] = 0;
    m_mix = 0;
    m_acc = 0;
    m_pdm = 0;
  endtask

  task automatic model_step();
    int s;
    int nmix;
    s = m_acc + m_mix;
    m_pdm = (s >= 128) ? 1 : 0;
    m_acc = s % 128;
    nmix = 0;
    for (int i = 0; i < 3; i++)
      if (gate[i]) nmix += m_env[i];
    m_mix = nmix;
    for (int i = 0; i < 3; i++) begin
      if (trig[i]) m_env[i] = 31;
      else if (frame_tick)
        m_env[i] = (m_env[i] > dec[i]) ? m_env[i] - dec[i] : 0;
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    if (!rst_n) model_reset();
    else model_step();
    @(negedge clk);
    checks++;
    if (mix !== 7'(m_mix)) begin
      errors++;
      $display("FAIL model_mix t=%0t: got %0d expected %0d",
               $time, mix, m_mix);
    end
    checks++;
    if (pdm_out !== 1'(m_pdm)) begin
      errors++;
      $display("FAIL model_pdm t=%0t: got %0d expected %0d",
               $time, pdm_out, m_pdm);
    end
  endtask

  task automatic idle_inputs();
    frame_tick = 1'b0;
    trig = '0;
  endtask

  task automatic test_reset();
    #1 rst_n = 1'b0;
    model_reset();
    for (int k = 0; k < 40; k++) begin
      frame_tick = 1'($urandom);
      trig = 3'($urandom);
      gate = 3'($urandom);
      cyc();
    end
    idle_inputs();
    gate = '0;
    rst_n = 1'b1;
    for (int k = 0; k < 1000; k++) begin
      cyc();
      checks++;
      if (mix !== 7'd0 || pdm_out !== 1'b0) begin
        errors++;
        $display("FAIL reset_silent: got mix=%0d pdm=%0d expected 0 0",
                 mix, pdm_out);
      end
    end
  endtask

  task automatic test_single_density();
    int ones;
    gate = 3'b001;
    trig = 3'b001;
    cyc();
    trig = '0;
    cyc();
    checks++;
    if (mix !== 7'd31) begin
      errors++;
      $display("FAIL single_mix: got %0d expected 31", mix);
    end
    ones = 0;
    for (int k = 0; k < 128; k++) begin
      cyc();
      ones += int'(pdm_out);
    end
    checks++;
    if (ones != 31) begin
      errors++;
      $display("FAIL single_density: got %0d expected 31", ones);
    end
  endtask

  task automatic test_decay();
    int exp;
    gate = 3'b001;
    trig = 3'b001;
    cyc();
    trig = '0;
    for (int k = 0; k < 8; k++) begin
      frame_tick = 1'b1;
      cyc();
    end
    frame_tick = 1'b0;
    cyc();
    checks++;
    if (mix !== 7'd23) begin
      errors++;
      $display("FAIL decay_v0: got %0d expected 23", mix);
    end
    gate = 3'b010;
    trig = 3'b010;
    cyc();
    trig = '0;
    for (int k = 1; k <= 17; k++) begin
      frame_tick = 1'b1;
      cyc();
      frame_tick = 1'b0;
      cyc();
      exp = 31 - 2 * k;
      if (exp < 0) exp = 0;
      checks++;
      if (mix !== 7'(exp)) begin
        errors++;
        $display("FAIL decay_v1 tick %0d: got %0d expected %0d",
                 k, mix, exp);
      end
    end
  endtask

  task automatic test_simul_retrig();
    gate = 3'b100;
    trig = 3'b100;
    frame_tick = 1'b1;
    cyc();
    idle_inputs();
    cyc();
    checks++;
    if (mix !== 7'd31) begin
      errors++;
      $display("FAIL trig_vs_tick: got %0d expected 31", mix);
    end
    gate = 3'b010;
    trig = 3'b010;
    cyc();
    trig = '0;
    for (int k = 0; k < 11; k++) begin
      frame_tick = 1'b1;
      cyc();
    end
    frame_tick = 1'b0;
    cyc();
    checks++;
    if (mix !== 7'd9) begin
      errors++;
      $display("FAIL retrig_pre: got %0d expected 9", mix);
    end
    trig = 3'b010;
    cyc();
    trig = '0;
    cyc();
    checks++;
    if (mix !== 7'd31) begin
      errors++;
      $display("FAIL retrig: got %0d expected 31", mix);
    end
  endtask

  task automatic test_full_mix_async_reset();
    int ones;
    logic g1;
    gate = 3'b111;
    trig = 3'b111;
    cyc();
    trig = '0;
    cyc();
    checks++;
    if (mix !== 7'd93) begin
      errors++;
      $display("FAIL full_mix: got %0d expected 93", mix);
    end
    ones = 0;
    for (int k = 0; k < 128; k++) begin
      cyc();
      ones += int'(pdm_out);
    end
    checks++;
    if (ones != 93) begin
      errors++;
      $display("FAIL full_density: got %0d expected 93", ones);
    end
    g1 = 1'b1;
    for (int k = 0; k < 20; k++) begin
      g1 = ~g1;
      gate = {1'b1, g1, 1'b1};
      cyc();
      checks++;
      if (mix !== (g1 ? 7'd93 : 7'd62)) begin
        errors++;
        $display("FAIL gate_toggle %0d: got %0d expected %0d",
                 k, mix, g1 ? 93 : 62);
      end
    end
    gate = 3'b111;
    cyc();
    cyc();
    @(posedge clk);
    model_step();
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    checks++;
    if (mix !== 7'd0 || pdm_out !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: got mix=%0d pdm=%0d expected 0 0",
               mix, pdm_out);
    end
    @(negedge clk);
    cyc();
    rst_n = 1'b1;
    for (int k = 0; k < 50; k++) begin
      cyc();
      checks++;
      if (mix !== 7'd0) begin
        errors++;
        $display("FAIL post_reset_silent: got %0d expected 0", mix);
      end
    end
    trig = 3'b001;
    cyc();
    trig = '0;
    cyc();
    checks++;
    if (mix !== 7'd31) begin
      errors++;
      $display("FAIL post_reset_trig: got %0d expected 31", mix);
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 3000; k++) begin
      trig[0] = ($urandom_range(63) == 0);
      trig[1] = ($urandom_range(63) == 0);
      trig[2] = ($urandom_range(63) == 0);
      frame_tick = ($urandom_range(15) == 0);
      gate = 3'($urandom);
      cyc();
    end
    idle_inputs();
  endtask

  initial begin
    rst_n = 1'b1;
    frame_tick = 1'b0;
    trig = '0;
    gate = '0;
    model_reset();
    test_reset();
    test_single_density();
    test_decay();
    test_simul_retrig();
    test_full_mix_async_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/audio_voice_mixer.md
# audio_voice_mixer

Three-voice envelope mixer and first-order sigma-delta modulator. It sits directly downstream of the demo's sound generators (kick square, snare noise, lead note) and directly upstream of the TinyAudio PMOD pin. It replaces the "gate ANDed with an x-window" width trick with real per-voice 5-bit envelopes. The voices are summed into a 7-bit level and converted to a 1-bit pulse-density stream at the pixel clock.

## Interface

Parameters:
- `NUM_VOICES`, default 3: number of voices. The mix width below is sized for 3.
- `DECAY0`, default 1: envelope decrement per frame tick for voice 0 (kick).
- `DECAY1`, default 2: envelope decrement per frame tick for voice 1 (snare).
- `DECAY2`, default 2: envelope decrement per frame tick for voice 2 (lead).

Ports (one clock; reset is asynchronous and active-low):
- `clk`, input, 1: pixel clock, 25.175 MHz nominal.
- `rst_n`, input, 1: asynchronous active-low reset.
- `frame_tick`, input, 1: single-cycle pulse, once per frame (x==0 && y==0).
- `trig`, input, NUM_VOICES: single-cycle per-voice note-on; restarts that voice's envelope.
- `gate`, input, NUM_VOICES: raw per-voice oscillator bits (square, noise, note).
- `mix`, output, 7: registered sum of gated envelopes, range 0..93.
- `pdm_out`, output, 1: registered sigma-delta bit. Drives all 8 `uio_out` bits at top level.

## Operation

**Envelope (per voice i)**
- `env[i]` is 5 bits.
- `trig[i]` loads 31.
- Otherwise, on `frame_tick`: `env[i] <= (env[i] > DECAYi) ? env[i] - DECAYi : 0`.
- The envelope saturates at 0 and never wraps.
- `trig[i]` and `frame_tick` in the same cycle: trig wins, env becomes 31 with no decrement that cycle.
- `trig[i]` while env is nonzero: reload to 31 (retrigger).

**Mix**
- `mix <= Σ (gate[i] ? env[i] : 0)`, computed in 7 bits.
- Maximum is 93, so there is no overflow and no clipping logic.
- `gate` is sampled raw. It must be registered upstream.

**Sigma-delta**
- Accumulator `acc` is 7 bits.
- Each cycle: `{pdm_out, acc} <= acc + mix`, an 8-bit add whose carry becomes the output bit.
- Over any 128 consecutive cycles with constant `mix = M`, `pdm_out` is high exactly M times.
- No idle state. With `mix = 0`, `acc` holds its value and `pdm_out` stays 0.

**Reset values**
- `env` = 0, `mix` = 0, `acc` = 0, `pdm_out` = 0.
- Async assertion clears all of these immediately, mid-note included.
- Deassertion is synchronised at top level. There is no further recovery logic here.

## Timing

- `trig[i]` at cycle t: `env[i]` = 31 at t+1. `mix` reflects it at t+2, with `gate` at t+1. `pdm_out` reflects the new `mix` from t+3.
- `gate` to `mix`: 1 cycle. `mix` to `pdm_out` density: 1 cycle.
- `frame_tick` at cycle t: decremented env visible at t+1.
- No handshakes. All inputs are single-cycle strobes or levels, and the block never stalls.

## Structure

- Shared package `audio_pkg` holds:
  - `ENV_W=5`, `ENV_MAX=5'd31`, `MIX_W=7`, `ACC_W=7`
  - the voice indices `V_KICK=0`, `V_SNARE=1`, `V_LEAD=2`
- One sub-module: `audio_envelope`, a single-voice 5-bit saturating decay counter with parameter DECAY, trig priority and async reset.
  - It is instantiated NUM_VOICES times via generate, with DECAY selected per index.
- The mix adder and the sigma-delta accumulator stay in the top of this block.

## Test plan

1. **Reset behaviour.** Hold `rst_n` low with random `gate`/`trig`/`frame_tick` → `mix` = 0 and `pdm_out` = 0 throughout. Release with all inputs 0 → both outputs stay 0 for 1000 cycles.
2. **Single voice density.** `trig[0]` once, `gate[0]` held 1, no `frame_tick` → `mix` = 31 from cycle 2. Over the next 128 cycles `pdm_out` is high exactly 31 times.
3. **Decay rates.**
   - Voice 0: after `trig`, 8 `frame_tick`s → env 23, `mix` 23.
   - Voice 1: 15 ticks → 1, 16th tick → 0, 17th tick stays 0.
4. **Simultaneous and retrigger.**
   - `trig[2]` coincident with `frame_tick` → env 31, not 29.
   - Retrigger voice 1 at env 9 → env 31 next cycle.
5. **Full mix.** All three voices triggered, all gates 1 → `mix` = 93, with exactly 93 ones per 128 cycles. Toggling `gate[1]` only: `mix` alternates 93/62 one cycle after the gate.
6. **Async reset mid-note.** Assert `rst_n` low asynchronously between clock edges during case 5 → `mix`, `pdm_out` and all envelopes read 0 before the next edge. After release, output stays silent until the next `trig`.
